// File: rtl/encoder_param_ctrl.sv
// Rotary-encoder parameter bank controller: browse / edit (shadow) / commit.
// Optional acceleration on repeated same-direction steps is enabled by ENC_PARAM_ACCEL_EN.
module encoder_param_ctrl #(
    parameter int NUM_PARAMS  = 4,
    parameter int WIDTH       = 8,
    parameter int MIN_VAL     = 0,
    parameter int MAX_VAL     = 99,
    parameter int DEFAULT_VAL = 50,
    parameter int TIMEOUT     = 625_000_000,
    parameter int ACCEL_WIN   = 12_500_000,
    parameter int ACCEL_STEP  = 10
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              pul_inc,
    input  logic                              pul_dec,
    input  logic                              btn,
    output logic [$clog2(NUM_PARAMS)-1:0]     sel_idx,
    output logic                              edit_mode,
    output logic [WIDTH-1:0]                  cur_val,
    output logic [NUM_PARAMS*WIDTH-1:0]       params,
    output logic                              upd,
    output logic [$clog2(NUM_PARAMS)-1:0]     upd_idx
);

    localparam int IDX_W = $clog2(NUM_PARAMS);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam logic [WIDTH:0]     MAX_X = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0]     MIN_X = (WIDTH+1)'(MIN_VAL);
    localparam logic [WIDTH-1:0]   DEF_V = WIDTH'(DEFAULT_VAL);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_PARAMS - 1);

    typedef enum logic [1:0] {BROWSE, EDIT, COMMIT} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  sel_r;
    logic [WIDTH-1:0]  shadow;
    logic [WIDTH-1:0]  bank [NUM_PARAMS];
    logic [TO_W-1:0]   to_cnt;
    logic [WIDTH-1:0]  step;

    function automatic logic [WIDTH-1:0] sat_add(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] s);
        logic [WIDTH:0] sum;
        sum = {1'b0, v} + {1'b0, s};
        if (sum > MAX_X) return MAX_X[WIDTH-1:0];
        return sum[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sat_sub(input logic [WIDTH-1:0] v,
                                                 input logic [WIDTH-1:0] s);
        if ({1'b0, v} < ({1'b0, s} + MIN_X)) return MIN_X[WIDTH-1:0];
        return v - s;
    endfunction

    // Input stage: 2-FF synchronisers plus edge-detect delay, all preset to 1
    logic inc_p0, inc_p1, inc_p2;
    logic dec_p0, dec_p1, dec_p2;
    logic btn_p0, btn_p1, btn_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            {inc_p0, inc_p1, inc_p2} <= 3'b111;
            {dec_p0, dec_p1, dec_p2} <= 3'b111;
            {btn_p0, btn_p1, btn_p2} <= 3'b111;
        end else begin
            {inc_p0, inc_p1, inc_p2} <= {pul_inc, inc_p0, inc_p1};
            {dec_p0, dec_p1, dec_p2} <= {pul_dec, dec_p0, dec_p1};
            {btn_p0, btn_p1, btn_p2} <= {btn, btn_p0, btn_p1};
        end
    end

    logic ev_inc, ev_dec, ev_btn, rot_inc, rot_dec, timeout_hit;
    assign ev_inc      = inc_p1 & ~inc_p2;
    assign ev_dec      = dec_p1 & ~dec_p2;
    assign ev_btn      = btn_p1 & ~btn_p2;
    assign rot_inc     = ev_inc & ~ev_dec;
    assign rot_dec     = ev_dec & ~ev_inc;
    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));

`ifdef ENC_PARAM_ACCEL_EN
    localparam int AW = $clog2(ACCEL_WIN + 1) + 1;
    logic [AW-1:0] acc_tmr;
    logic          acc_armed, acc_dir, acc_hit, edit_rot;

    assign edit_rot = (state == EDIT) && !ev_btn && (rot_inc || rot_dec);
    assign acc_hit  = acc_armed && (acc_dir == rot_inc) && (acc_tmr < AW'(ACCEL_WIN));
    assign step     = acc_hit ? WIDTH'(ACCEL_STEP) : WIDTH'(1);

    // Timer measures the gap since the last edit step; expiry disarms acceleration
    always_ff @(posedge clk) begin
        if (rst || state != EDIT) begin
            acc_tmr   <= '0;
            acc_armed <= 1'b0;
            acc_dir   <= 1'b0;
        end else if (edit_rot) begin
            acc_tmr   <= '0;
            acc_armed <= 1'b1;
            acc_dir   <= rot_inc;
        end else if (acc_armed) begin
            if (acc_tmr >= AW'(ACCEL_WIN)) acc_armed <= 1'b0;
            else                           acc_tmr   <= acc_tmr + AW'(1);
        end
    end
`else
    assign step = WIDTH'(1);
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= BROWSE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            BROWSE: if (ev_btn) state_nxt = EDIT;
            EDIT: begin
                if (ev_btn)                      state_nxt = COMMIT;
                else if (!(rot_inc || rot_dec) && timeout_hit) state_nxt = BROWSE;
            end
            COMMIT:  state_nxt = BROWSE;
            default: state_nxt = BROWSE;
        endcase
    end

    always_comb begin
        edit_mode = (state == EDIT);
        upd       = (state == COMMIT);
        upd_idx   = (state == COMMIT) ? sel_r : '0;
    end

    // Datapath: selection, shadow edit, timeout and bank write-back
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_r  <= '0;
            shadow <= DEF_V;
            to_cnt <= '0;
            for (int i = 0; i < NUM_PARAMS; i++) bank[i] <= DEF_V;
        end else begin
            case (state)
                BROWSE: begin
                    if (ev_btn) begin
                        shadow <= bank[sel_r];
                        to_cnt <= '0;
                    end else if (rot_inc) begin
                        sel_r <= (sel_r == LAST_IDX) ? '0 : sel_r + IDX_W'(1);
                    end else if (rot_dec) begin
                        sel_r <= (sel_r == '0) ? LAST_IDX : sel_r - IDX_W'(1);
                    end
                end
                EDIT: begin
                    if (!ev_btn) begin
                        if (rot_inc) begin
                            shadow <= sat_add(shadow, step);
                            to_cnt <= '0;
                        end else if (rot_dec) begin
                            shadow <= sat_sub(shadow, step);
                            to_cnt <= '0;
                        end else begin
                            to_cnt <= to_cnt + TO_W'(1);
                        end
                    end
                end
                COMMIT:  bank[sel_r] <= shadow;
                default: ;
            endcase
        end
    end

    assign sel_idx = sel_r;
    assign cur_val = (state == EDIT) ? shadow : bank[sel_r];

    for (genvar g = 0; g < NUM_PARAMS; g++) begin : g_flat
        assign params[g*WIDTH +: WIDTH] = bank[g];
    end

endmodule
